// File: rtl/ecc_pkg.sv
// Shared constants and per-batch (136,128) parity contribution for the page ECC encoder/checker.
// Combinational helpers only; no latency, no backpressure.
package ecc_pkg;
  localparam int         DATA_WIDTH   = 16;
  localparam int         PAGE_BATCHES = 8;
  localparam logic [3:0] IDLE_BATCH   = 4'd8;
  localparam logic [3:0] LAST_BATCH   = 4'd7;

  typedef enum logic {ST_ACC, ST_PAD} enc_state_e;

  // Bit j of batch b is data bit d = b*16+j. For j<15 the syndrome d+1 is {b, j+1};
  // for j=15 it is {b+1, 4'b0}, so w[15] only touches the upper code bits.
  function automatic logic [7:0] batch_parity(input logic [3:0] b,
                                               input logic [DATA_WIDTH-1:0] w);
    logic [7:0] p;
    logic [3:0] b_inc;
    logic       lo_par;
    p      = '0;
    b_inc  = b + 4'd1;
    lo_par = ^w[DATA_WIDTH-2:0];
    for (int j = 0; j < DATA_WIDTH - 1; j++) begin
      if (w[j]) p[3:0] = p[3:0] ^ 4'(j + 1);
    end
    p[6:4] = (b[2:0] & {3{lo_par}}) ^ (b_inc[2:0] & {3{w[DATA_WIDTH-1]}});
    p[7]   = (b == LAST_BATCH) & w[DATA_WIDTH-1];
    return p;
  endfunction
endpackage

// File: rtl/ecc_encoder_if.sv
// Page write bus: upstream words in, registered words plus page code out to the SRAM writer.
// master drives the page words; slave is the encoder.
interface ecc_encoder_if;
  import ecc_pkg::*;
  logic [3:0]            in_batch;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  end_of_packet;
  logic                  in_ready;
  logic [3:0]            out_batch;
  logic [DATA_WIDTH-1:0] out_data;
  logic [7:0]            ecc_code;
  logic                  ecc_valid;

  modport master (
    output in_batch, in_data, end_of_packet,
    input  in_ready, out_batch, out_data, ecc_code, ecc_valid
  );
  modport slave (
    input  in_batch, in_data, end_of_packet,
    output in_ready, out_batch, out_data, ecc_code, ecc_valid
  );
endinterface

// File: rtl/ecc_batch_parity.sv
// Combinational code contribution of one batch word; zero latency, no backpressure.
module ecc_batch_parity
  import ecc_pkg::*;
(
  input  logic [3:0]            batch,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [7:0]            parity
);
  assign parity = batch_parity(batch, data);
endmodule

// File: rtl/ecc_encoder.sv
// Page ECC encoder: data passes through with 1 cycle latency, code shown alongside batch 7.
// in_ready drops while a short packet is zero-padded to a full page.
module ecc_encoder
  import ecc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ecc_encoder_if.slave bus
);
  enc_state_e            state, state_n;
  logic [7:0]            acc, acc_n, code_n, contrib;
  logic [3:0]            last_batch, last_n, pad_batch, pad_n, ob_n;
  logic [DATA_WIDTH-1:0] od_n;
  logic                  vld_n, word_vld;

  ecc_batch_parity u_parity (
    .batch  (bus.in_batch),
    .data   (bus.in_data),
    .parity (contrib)
  );

  // Batch codes above 7 carry no word; treated like IDLE_BATCH.
  assign word_vld     = bus.in_batch < 4'(PAGE_BATCHES);
  assign bus.in_ready = (state == ST_ACC);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    last_n  = last_batch;
    pad_n   = pad_batch;
    ob_n    = IDLE_BATCH;
    od_n    = bus.out_data;
    code_n  = bus.ecc_code;
    vld_n   = 1'b0;
    case (state)
      ST_ACC: begin
        if (word_vld) begin
          ob_n   = bus.in_batch;
          od_n   = bus.in_data;
          last_n = bus.in_batch;
          if (bus.in_batch == LAST_BATCH) begin
            code_n = acc ^ contrib;
            vld_n  = 1'b1;
            acc_n  = '0;
          end else begin
            acc_n = acc ^ contrib;
            if (bus.end_of_packet) begin
              state_n = ST_PAD;
              pad_n   = bus.in_batch + 4'd1;
            end
          end
        end else if (bus.end_of_packet && last_batch < LAST_BATCH) begin
          state_n = ST_PAD;
          pad_n   = last_batch + 4'd1;
        end
      end
      ST_PAD: begin
        // Zero words leave the accumulator untouched.
        ob_n  = pad_batch;
        od_n  = '0;
        pad_n = pad_batch + 4'd1;
        if (pad_batch == LAST_BATCH) begin
          code_n  = acc;
          vld_n   = 1'b1;
          acc_n   = '0;
          last_n  = LAST_BATCH;
          state_n = ST_ACC;
        end
      end
      default: state_n = ST_ACC;
    endcase
  end

  // last_batch resets to 7 so an idle end_of_packet with no open page is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_ACC;
      acc           <= '0;
      last_batch    <= LAST_BATCH;
      pad_batch     <= '0;
      bus.out_batch <= IDLE_BATCH;
      bus.out_data  <= '0;
      bus.ecc_code  <= '0;
      bus.ecc_valid <= 1'b0;
    end else begin
      state         <= state_n;
      acc           <= acc_n;
      last_batch    <= last_n;
      pad_batch     <= pad_n;
      bus.out_batch <= ob_n;
      bus.out_data  <= od_n;
      bus.ecc_code  <= code_n;
      bus.ecc_valid <= vld_n;
    end
  end
endmodule

// File: tb/tb_ecc_encoder.sv
// Self-checking bench for ecc_encoder: directed spec cases plus random packets against a bitwise code model.
module tb_ecc_encoder;
  import ecc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecc_encoder_if bus ();
  ecc_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  b;
    logic [15:0] d;
    logic        v;
    logic [7:0]  c;
  } rec_t;

  rec_t        got_q[$];
  rec_t        exp_q[$];
  logic [7:0]  code_q[$];
  logic [15:0] pg[8];
  int          checks = 0;
  int          passes = 0;

  // Every shown word (and any ecc_valid pulse) is logged mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.out_batch !== IDLE_BATCH || bus.ecc_valid === 1'b1)) begin
      got_q.push_back('{bus.out_batch, bus.out_data, bus.ecc_valid, bus.ecc_code});
      if (bus.ecc_valid === 1'b1) code_q.push_back(bus.ecc_code);
    end
  end

  // Code = XOR of (d+1) over every set data bit d of the page.
  function automatic logic [7:0] model_code();
    logic [7:0] c;
    c = 8'h00;
    for (int d = 0; d < 128; d++) if (pg[d/16][d%16]) c ^= 8'(d + 1);
    return c;
  endfunction

  function automatic int stream_diff();
    int n;
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= got_q.size() || i >= exp_q.size()) return i;
      if (got_q[i].b !== exp_q[i].b || got_q[i].d !== exp_q[i].d || got_q[i].v !== exp_q[i].v)
        return i;
      if (exp_q[i].v && got_q[i].c !== exp_q[i].c) return i;
    end
    return -1;
  endfunction

  function automatic string rec_s(input int i, input bit from_got);
    rec_t r;
    if (from_got ? (i >= got_q.size()) : (i >= exp_q.size())) return "none";
    r = from_got ? got_q[i] : exp_q[i];
    return $sformatf("batch %0d data %04h valid %0b code %02h", r.b, r.d, r.v, r.c);
  endfunction

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    code_q.delete();
  endtask

  task automatic zero_page();
    for (int i = 0; i < 8; i++) pg[i] = 16'h0000;
  endtask

  task automatic expect_page(input int n);
    logic [7:0] c;
    c = model_code();
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{4'(i), (i < n) ? pg[i] : 16'h0000, (i == 7), (i == 7) ? c : 8'h00});
  endtask

  task automatic send_word(input logic [3:0] b, input logic [15:0] w, input logic eop);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL in_ready_wait: in_ready %b after 50 cycles, required 1", bus.in_ready);
    end
    bus.in_batch      = b;
    bus.in_data       = w;
    bus.end_of_packet = eop;
    @(posedge clk); #1;
    bus.in_batch      = IDLE_BATCH;
    bus.end_of_packet = 1'b0;
  endtask

  task automatic send_page(input int n, input bit close_idle);
    for (int i = 0; i < n; i++) send_word(4'(i), pg[i], (i == n - 1) && !close_idle);
    if (close_idle) send_word(IDLE_BATCH, 16'h0000, 1'b1);
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    @(posedge clk); #1;
    checks++; if (bus.out_batch !== IDLE_BATCH) $display("FAIL rst_out_batch: got %0d required 8", bus.out_batch); else passes++;
    checks++; if (bus.out_data !== 16'h0) $display("FAIL rst_out_data: got %04h required 0000", bus.out_data); else passes++;
    checks++; if (bus.ecc_code !== 8'h0) $display("FAIL rst_ecc_code: got %02h required 00", bus.ecc_code); else passes++;
    checks++; if (bus.ecc_valid !== 1'b0) $display("FAIL rst_ecc_valid: got %b required 0", bus.ecc_valid); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); else passes++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_page();
    int idx;
    clear_logs(); zero_page();
    send_word(4'd0, 16'h0000, 1'b0);
    checks++; if (bus.out_batch !== 4'd0) $display("FAIL zero_latency: out_batch %0d required 0", bus.out_batch); else passes++;
    for (int i = 1; i < 8; i++) send_word(4'(i), 16'h0000, 1'b0);
    expect_page(8); drain();
    idx = stream_diff();
    checks++; if (idx >= 0) $display("FAIL zero_stream: rec %0d got [%s] required [%s]", idx, rec_s(idx, 1), rec_s(idx, 0)); else passes++;
    checks++; if (code_q.size() != 1 || code_q[0] !== 8'h00) $display("FAIL zero_code: %0d pulses first %02h required 1 pulse 00", code_q.size(), (code_q.size() > 0) ? code_q[0] : 8'hxx); else passes++;
  endtask

  task automatic test_single_bits();
    logic [3:0]  tb_b[3] = '{4'd0, 4'd4, 4'd7};
    logic [15:0] tb_w[3] = '{16'h0001, 16'h0080, 16'h8000};
    logic [7:0]  tb_c[3] = '{8'h01, 8'h48, 8'h80};
    int idx;
    for (int t = 0; t < 3; t++) begin
      clear_logs(); zero_page();
      pg[tb_b[t]] = tb_w[t];
      send_page(8, 1'b0); expect_page(8); drain();
      idx = stream_diff();
      checks++; if (idx >= 0) $display("FAIL single%0d_stream: rec %0d got [%s] required [%s]", t, idx, rec_s(idx, 1), rec_s(idx, 0)); else passes++;
      checks++; if (code_q.size() != 1 || code_q[0] !== tb_c[t]) $display("FAIL single%0d_code: %0d pulses first %02h required %02h", t, code_q.size(), (code_q.size() > 0) ? code_q[0] : 8'hxx, tb_c[t]); else passes++;
    end
  endtask

  task automatic test_all_ones();
    int idx;
    clear_logs();
    for (int i = 0; i < 8; i++) pg[i] = 16'hFFFF;
    send_page(8, 1'b0); expect_page(8); drain();
    idx = stream_diff();
    checks++; if (idx >= 0) $display("FAIL ones_stream: rec %0d got [%s] required [%s]", idx, rec_s(idx, 1), rec_s(idx, 0)); else passes++;
    checks++; if (code_q.size() != 1 || code_q[0] !== 8'h80) $display("FAIL ones_code: %0d pulses first %02h required 80", code_q.size(), (code_q.size() > 0) ? code_q[0] : 8'hxx); else passes++;
  endtask

  task automatic test_short_packet();
    int idx, n;
    clear_logs(); zero_page();
    for (int i = 0; i < 3; i++) pg[i] = 16'h0001;
    send_word(4'd0, 16'h0001, 1'b0);
    send_word(4'd1, 16'h0001, 1'b0);
    send_word(4'd2, 16'h0001, 1'b1);
    // Junk presented while padding must be ignored.
    bus.in_batch      = 4'($urandom_range(0, 7));
    bus.in_data       = 16'($urandom);
    bus.end_of_packet = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    bus.in_batch = IDLE_BATCH; bus.end_of_packet = 1'b0;
    checks++; if (n != 5) $display("FAIL short_ready_low: %0d cycles required 5", n); else passes++;
    expect_page(3); drain();
    idx = stream_diff();
    checks++; if (idx >= 0) $display("FAIL short_stream: rec %0d got [%s] required [%s]", idx, rec_s(idx, 1), rec_s(idx, 0)); else passes++;
    checks++; if (code_q.size() != 1 || code_q[0] !== 8'h31) $display("FAIL short_code: %0d pulses first %02h required 31", code_q.size(), (code_q.size() > 0) ? code_q[0] : 8'hxx); else passes++;
  endtask

  task automatic test_close_idle();
    int idx;
    clear_logs(); zero_page();
    pg[0] = 16'h0001;
    send_page(1, 1'b1); expect_page(1); drain();
    idx = stream_diff();
    checks++; if (idx >= 0) $display("FAIL close_stream: rec %0d got [%s] required [%s]", idx, rec_s(idx, 1), rec_s(idx, 0)); else passes++;
    checks++; if (code_q.size() != 1 || code_q[0] !== 8'h01) $display("FAIL close_code: %0d pulses first %02h required 01", code_q.size(), (code_q.size() > 0) ? code_q[0] : 8'hxx); else passes++;
    clear_logs();
    send_word(IDLE_BATCH, 16'h0000, 1'b1); drain();
    checks++; if (got_q.size() != 0) $display("FAIL close_second_eop: %0d words emitted required 0", got_q.size()); else passes++;
  endtask

  task automatic test_reset_mid_page();
    int idx;
    clear_logs(); zero_page();
    pg[1] = 16'($urandom) | 16'h0001;
    for (int i = 0; i < 4; i++) begin
      send_word(4'(i), pg[i], 1'b0);
      exp_q.push_back('{4'(i), pg[i], 1'b0, 8'h00});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checks++; if (bus.out_batch !== IDLE_BATCH) $display("FAIL midrst_out_batch: got %0d required 8", bus.out_batch); else passes++;
    checks++; if (bus.ecc_valid !== 1'b0) $display("FAIL midrst_ecc_valid: got %b required 0", bus.ecc_valid); else passes++;
    checks++; if (bus.out_data !== 16'h0) $display("FAIL midrst_out_data: got %04h required 0000", bus.out_data); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b required 1", bus.in_ready); else passes++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    zero_page();
    send_page(8, 1'b0); expect_page(8); drain();
    idx = stream_diff();
    checks++; if (idx >= 0) $display("FAIL midrst_stream: rec %0d got [%s] required [%s]", idx, rec_s(idx, 1), rec_s(idx, 0)); else passes++;
    checks++; if (code_q.size() != 1 || code_q[0] !== 8'h00) $display("FAIL midrst_code: %0d pulses first %02h required 00", code_q.size(), (code_q.size() > 0) ? code_q[0] : 8'hxx); else passes++;
  endtask

  task automatic test_back_to_back();
    int idx, da, db;
    clear_logs();
    da = $urandom_range(0, 127);
    db = $urandom_range(0, 127);
    zero_page(); pg[da/16][da%16] = 1'b1;
    send_page(8, 1'b0); expect_page(8);
    zero_page(); pg[db/16][db%16] = 1'b1;
    send_page(8, 1'b0); expect_page(8);
    drain();
    idx = stream_diff();
    checks++; if (idx >= 0) $display("FAIL b2b_stream: rec %0d got [%s] required [%s]", idx, rec_s(idx, 1), rec_s(idx, 0)); else passes++;
    checks++;
    if (code_q.size() != 2 || code_q[0] !== 8'(da + 1) || code_q[1] !== 8'(db + 1))
      $display("FAIL b2b_codes: %0d pulses got %02h,%02h required %02h,%02h", code_q.size(),
               (code_q.size() > 0) ? code_q[0] : 8'hxx, (code_q.size() > 1) ? code_q[1] : 8'hxx, 8'(da + 1), 8'(db + 1));
    else passes++;
  endtask

  task automatic test_random();
    int idx, n;
    bit ci;
    clear_logs();
    for (int p = 0; p < 15; p++) begin
      n  = $urandom_range(1, 8);
      ci = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) pg[i] = (i < n) ? 16'($urandom) : 16'h0000;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) send_word(IDLE_BATCH, 16'($urandom), 1'b0);
        send_word(4'(i), pg[i], (i == n - 1) && !ci);
      end
      if (ci) send_word(IDLE_BATCH, 16'($urandom), 1'b1);
      expect_page(n);
    end
    drain();
    idx = stream_diff();
    checks++; if (idx >= 0) $display("FAIL rand_stream: rec %0d got [%s] required [%s]", idx, rec_s(idx, 1), rec_s(idx, 0)); else passes++;
    checks++; if (code_q.size() != 15) $display("FAIL rand_pulses: got %0d required 15", code_q.size()); else passes++;
  endtask

  initial begin
    bus.in_batch      = IDLE_BATCH;
    bus.in_data       = 16'h0000;
    bus.end_of_packet = 1'b0;
    test_reset();
    test_zero_page();
    test_single_bits();
    test_all_ones();
    test_short_packet();
    test_close_idle();
    test_reset_mid_page();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ecc_encoder.md
Name: ecc_encoder

Overview:
- Write-side counterpart of the page ECC checker. It takes a page of 8 half-words (batch 0..7, 16 bits each, 128 data bits) on its way to SRAM.
- It passes the data through with one cycle of latency and computes the page's 8-bit (136,128) code. The code is presented together with batch 7 so the writer stores data and code in the same cycle.
- Short packets are zero-padded to a full page so the reader always checks 8 batches.

Parameters:
DATA_WIDTH, 16, half-word width; only 16 is supported.
PAGE_BATCHES, 8, half-words per page; only 8 is supported.
IDLE_BATCH, 4'd8, batch code meaning "no word this cycle".

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_batch  in  4  position of in_data within the page, 0..7; IDLE_BATCH = no word
in_data  in  16  data half-word
end_of_packet  in  1  the word this cycle is the packet's last; with in_batch = 8 it closes an open page
in_ready  out  1  encoder accepts words; upstream holds its word while this is low
out_batch  out  4  registered batch to SRAM writer, 8 = idle
out_data  out  16  registered data to SRAM writer
ecc_code  out  8  page code, valid while ecc_valid = 1
ecc_valid  out  1  one-cycle pulse, coincident with out_batch = 7

Behaviour:
- Reset (async): state IDLE/ACC, accumulator 0, out_batch = 8, out_data = 0, ecc_code = 0, ecc_valid = 0, in_ready = 1.
- Code definition:
  - Data bit d = batch*16 + bit, range 0..127.
  - ecc_code[k] = XOR of data[d] over every d where bit k of (d+1) is 1.
  - Result: a single flipped data bit d yields syndrome d+1.
- Per-batch contribution for batch b and input word w:
  - k = 0..3: XOR of w[j] over j = 0..14 where bit k of (j+1) is 1. w[15] never contributes.
  - k = 4..6: (b[k-4] ? ^w[14:0] : 0) XOR ((b+1)[k-4] ? w[15] : 0), with b+1 taken as 4 bits.
  - k = 7: w[15] when b = 7, else 0.
- States:
  - ACC: accepting words. Covers idle, since the accumulator is 0 and the counter is at the page boundary.
  - PAD: emitting zero batches; in_ready = 0.
- ACC, valid word (in_batch != 8, in_ready = 1):
  - Next cycle: out_batch = in_batch, out_data = in_data.
  - The accumulator XORs in the contribution; last_batch records in_batch.
  - If in_batch = 7:
    - ecc_code is registered from accumulator ^ contribution, and ecc_valid = 1 in the same cycle out_batch = 7 is shown.
    - The accumulator is cleared.
  - If end_of_packet = 1 and in_batch = k < 7: go to PAD with pad_batch = k+1.
- ACC, in_batch = 8:
  - out_batch = 8 next cycle; out_data holds its value.
  - If end_of_packet = 1 and the page is open (last_batch < 7): go to PAD with pad_batch = last_batch+1. Otherwise nothing happens.
- PAD:
  - Each cycle: out_batch <= pad_batch, out_data <= 0, pad_batch++.
  - Zero words add nothing to the code.
  - When pad_batch = 7 is emitted, ecc_valid pulses with the final code, the accumulator clears, and the state returns to ACC.
  - Cycle count: EOP on batch k at cycle t gives PAD during t+1..t+7-k and pad outputs at t+2..t+8-k. in_ready = 1 again from cycle t+8-k.
  - Inputs are ignored while in PAD.
- Back-to-back pages: batch 0 may follow batch 7 directly; codes never mix between pages.
- Upstream guarantees ascending batch order within a page. The encoder uses in_batch as the position and does not reorder.
- rst mid-page: the page is dropped, with no ecc_valid and an all-reset state.

Decomposition:
- Shared package ecc_pkg, used by the encoder and the checker:
  - constants IDLE_BATCH, PAGE_BATCHES, DATA_WIDTH;
  - function batch_parity(b, w) returning the 8-bit contribution.
- One sub-module, ecc_batch_parity: combinational contribution of one batch. It is reusable by the checker.

Test Plan:
- Page of all-zero words, batches 0..7 back-to-back -> out_batch 0..7 one cycle later, ecc_valid once with out_batch 7, ecc_code = 0x00.
- Single set bit, all other data 0:
  - batch0 = 0x0001 -> 0x01;
  - batch4 = 0x0080 -> 0x48;
  - batch7 = 0x8000 -> 0x80.
- All-ones page (8 x 0xFFFF) -> ecc_code = 0x80.
- Short packet: batches 0..2 = 0x0001, end_of_packet with batch 2 ->
  - in_ready low 5 cycles;
  - out_batch 3..7 with out_data 0x0000;
  - ecc_code = 0x31 with batch 7.
- Close via in_batch = 8: batch0 = 0x0001, then end_of_packet with in_batch = 8 -> pad batches 1..7, ecc_code = 0x01. A second idle end_of_packet -> no effect.
- Reset and page isolation: rst asserted after batch 3 -> out_batch = 8 and no ecc_valid; the next full zero page gives 0x00. Two back-to-back single-bit pages give independent codes.
